// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-interface types and default widths
package mem_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM with registered read output
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset so contents survive clear.
    always_ff @(posedge clock) begin
        if (we && !clear) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register holds the last completed read; clear zeroes it.
    always_ff @(posedge clock) begin
        if (clear) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - RAM target with programmable wait states and done pulse
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              err
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    op_t               op_q, op_d;
    logic              err_q, err_d;
    logic              access;

    // Upper MAR bits do not select memory; they alias onto the low window.
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[31:ADDR_W];

    // State, counter and capture registers; clear aborts any access in flight.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_READ;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: capture on a single strobe, count down, then release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        access  = 1'b0;
        err_d   = (state_q == IDLE) && read && write;
        case (state_q)
            IDLE: begin
                if (read ^ write) begin
                    addr_d  = address[ADDR_W-1:0];
                    wdata_d = wdata;
                    op_d    = write ? OP_WRITE : OP_READ;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = (read || write) ? RELEASE : IDLE;
            end
            RELEASE: begin
                if (!read && !write) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clock (clock),
        .clear (clear),
        .we    (access && (op_q == OP_WRITE)),
        .re    (access && (op_q == OP_READ)),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign done = (state_q == DONE);
    assign busy = (state_q != IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic        rd [2];
    logic        wr [2];
    logic [31:0] rdata_v [2];
    logic        done_v [2];
    logic        busy_v [2];
    logic        err_v [2];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clock(clock), .clear(clear), .address(address), .wdata(wdata),
        .read(rd[0]), .write(wr[0]), .rdata(rdata_v[0]),
        .done(done_v[0]), .busy(busy_v[0]), .err(err_v[0])
    );

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .clear(clear), .address(address), .wdata(wdata),
        .read(rd[1]), .write(wr[1]), .rdata(rdata_v[1]),
        .done(done_v[1]), .busy(busy_v[1]), .err(err_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One complete access: strobe held until done, then dropped.
    task automatic do_access(input int s, input bit is_wr, input logic [31:0] a,
                             input logic [31:0] d, input int exp_lat,
                             input logic [31:0] exp_rd);
        int lat;
        lat = 99;
        address = a;
        wdata   = d;
        rd[s]   = !is_wr;
        wr[s]   = is_wr;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done_v[s]) begin
                lat = i - 1;
                break;
            end
        end
        check("latency", lat, exp_lat);
        if (!is_wr) check("rdata_at_done", rdata_v[s], exp_rd);
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        step();
        check("done_one_cycle", {31'd0, done_v[s]}, 32'd0);
        check("busy_after_done", {31'd0, busy_v[s]}, 32'd0);
    endtask

    initial begin
        int n_done;
        rd[0] = 1'b0; rd[1] = 1'b0;
        wr[0] = 1'b0; wr[1] = 1'b0;

        clear = 1'b1;
        step();
        check("reset_rdata", rdata_v[0], 32'd0);
        check("reset_done", {31'd0, done_v[0]}, 32'd0);
        check("reset_busy", {31'd0, busy_v[0]}, 32'd0);
        check("reset_err", {31'd0, err_v[0]}, 32'd0);
        clear = 1'b0;
        step();

        // Basic write then read-back.
        do_access(0, 1'b1, 32'h0000_00B6, 32'h0000_0034, 3, 32'h0);
        do_access(0, 1'b0, 32'h0000_00B6, 32'h0, 3, 32'h0000_0034);

        // Seed 0x10, then alias 0x200 onto 0x000.
        do_access(0, 1'b1, 32'h0000_0010, 32'h0000_0055, 3, 32'h0);
        do_access(0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 3, 32'h0);
        do_access(0, 1'b0, 32'h0000_0000, 32'h0, 3, 32'hDEAD_BEEF);

        // Illegal request for two cycles.
        address = 32'h0000_0010;
        wdata   = 32'h0000_00AA;
        rd[0] = 1'b1; wr[0] = 1'b1;
        step();
        check("err_cycle1", {31'd0, err_v[0]}, 32'd1);
        check("err_busy1", {31'd0, busy_v[0]}, 32'd0);
        check("err_done1", {31'd0, done_v[0]}, 32'd0);
        step();
        check("err_cycle2", {31'd0, err_v[0]}, 32'd1);
        check("err_busy2", {31'd0, busy_v[0]}, 32'd0);
        rd[0] = 1'b0; wr[0] = 1'b0;
        step();
        check("err_cleared", {31'd0, err_v[0]}, 32'd0);
        check("err_rdata_kept", rdata_v[0], 32'hDEAD_BEEF);
        do_access(0, 1'b0, 32'h0000_0010, 32'h0, 3, 32'h0000_0055);

        // Held read strobe: one done, then RELEASE until strobe drops.
        address = 32'h0000_0000;
        rd[0] = 1'b1;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done_v[0]) n_done++;
        end
        check("held_done_count", n_done, 1);
        check("held_busy", {31'd0, busy_v[0]}, 32'd1);
        check("held_rdata", rdata_v[0], 32'hDEAD_BEEF);
        rd[0] = 1'b0;
        step();
        check("held_release_exit", {31'd0, busy_v[0]}, 32'd0);
        do_access(0, 1'b1, 32'h0000_0020, 32'h0000_0077, 3, 32'h0);

        // Reset during WAIT aborts the write to 0x20.
        address = 32'h0000_0020;
        wdata   = 32'h0000_0011;
        wr[0] = 1'b1;
        step();
        step();
        check("abort_busy_before", {31'd0, busy_v[0]}, 32'd1);
        clear = 1'b1;
        wr[0] = 1'b0;
        step();
        check("abort_rdata", rdata_v[0], 32'd0);
        check("abort_done", {31'd0, done_v[0]}, 32'd0);
        check("abort_busy", {31'd0, busy_v[0]}, 32'd0);
        check("abort_err", {31'd0, err_v[0]}, 32'd0);
        clear = 1'b0;
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done_v[0]) n_done++;
        end
        check("abort_no_done", n_done, 0);
        do_access(0, 1'b0, 32'h0000_0020, 32'h0, 3, 32'h0000_0077);

        // Zero wait states on the second instance.
        do_access(1, 1'b1, 32'h0000_0005, 32'h0000_A5A5, 1, 32'h0);
        do_access(1, 1'b0, 32'h0000_0005, 32'h0, 1, 32'h0000_A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU datapath's RAM interface: the target that services `read`/`write` strobes issued by the control sequencer against the address held in MAR and the data held in MDR. It owns the 512-word main memory, inserts a programmable number of wait states, and returns read data with a one-cycle `done` pulse that the control unit uses to advance past memory T-states. It sits between the datapath's MAR/MDR outputs and MDR's memory-data input (`Mdatain`).

## Interface
- `ADDR_W`, 9, word-address width; memory depth is 2^ADDR_W words
- `DATA_W`, 32, word width
- `WAIT_CYCLES`, 2, wait states inserted before each access (0–15)

- `clock`  in  1  system clock, rising-edge active
- `clear`  in  1  reset, synchronous, active-high
- `address`  in  32  from MAR; only `[ADDR_W-1:0]` is used, upper bits ignored
- `wdata`  in  DATA_W  from MDR
- `read`  in  1  read request, level, held by requester until `done`
- `write`  in  1  write request, level, held by requester until `done`
- `rdata`  out  DATA_W  read data to MDR `Mdatain`; holds last read value
- `done`  out  1  one-cycle completion pulse
- `busy`  out  1  high whenever state is not IDLE
- `err`  out  1  one-cycle pulse on illegal request (`read` and `write` both high)

## Operation
- States: IDLE, WAIT, DONE, RELEASE.
- IDLE: at an edge with exactly one of `read`/`write` high, capture `address[ADDR_W-1:0]`, `wdata` and op; load wait counter with WAIT_CYCLES; go to WAIT.
- IDLE, both strobes high: pulse `err` the next cycle, capture nothing, stay IDLE; re-evaluated every cycle the condition persists.
- WAIT: at each edge, if counter is nonzero, decrement it. If it is zero, perform the access and go to DONE. A write stores the captured data. A read loads `rdata` from the captured address.
- The captured operation always completes. Strobes dropping or changing during WAIT are ignored.
- DONE: `done`=1 for exactly this cycle. At the next edge, go to IDLE if both strobes are low, else go to RELEASE.
- RELEASE: `done`=0. Wait until both strobes are low, then go to IDLE. Prevents a held strobe from starting a second access.
- `rdata` changes only on a completed read. Writes and errors leave it unchanged.
- Address wrap: none needed. Address is truncated to ADDR_W bits, so 0x200 aliases 0x000.
- Memory contents are not initialised by `clear` and survive reset.

## Timing
- Reset: `clear` high at an edge sets state to IDLE, counter to 0, `rdata` to 0, and `done`/`busy`/`err` to 0.
- Reset mid-operation aborts it. A pending write is not performed, and no `done` is issued.
- Request seen at edge N gives `busy`=1 from edge N and `done`=1 in the cycle after edge N+WAIT_CYCLES+1.
- Read data is valid in `rdata` in the same cycle as `done`, and remains valid afterwards.
- Default latency: 3 edges from request to `done`. With WAIT_CYCLES=0 it is 1 edge.
- Back-to-back accesses: a new request is accepted at the first edge in IDLE. Minimum spacing is WAIT_CYCLES+3 cycles between requests.
- `busy` deasserts in the cycle after DONE/RELEASE exits.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE, WAIT, DONE, RELEASE)
  - op type (OP_READ, OP_WRITE)
  - default ADDR_W/DATA_W constants, also used by the MAR/MDR blocks
- Sub-module `mem_array`: single-port synchronous RAM, 2^ADDR_W × DATA_W, with write enable and registered read output. It is driven from the captured address and the op, and asserted on the WAIT-to-DONE edge.
- The FSM, wait counter and capture registers live in `mem_responder`.

## Test plan
- Write, WAIT_CYCLES=2: `write`=1, `address`=0x0000_00B6, `wdata`=0x0000_0034 held until `done`. Required: `done` exactly 3 edges after the request, one cycle wide. Read back from 0xB6 returns 0x34 with `done`.
- Truncation/alias: write 0xDEADBEEF to `address` 0x0000_0200, then read `address` 0x000. Required: `rdata`=0xDEADBEEF.
- Illegal request: `read`=`write`=1 for 2 cycles with memory at 0x10 = 0x55. Required: `err` high for those cycles, no `done`, `busy`=0, address 0x10 still 0x55, `rdata` unchanged.
- Held strobe: `read` held 10 cycles. Required: exactly one `done` pulse, state RELEASE until `read` drops, then a new request is accepted.
- Reset mid-access: write to 0x20 with 0x11, assert `clear` during WAIT. Required: next cycle all outputs are 0, no `done`, address 0x20 keeps its prior value.
- WAIT_CYCLES=0: read request at edge N. Required: `done` and valid `rdata` in the cycle after edge N+1.
